branch_redirect_ctrl: RTL and testbench

Controls the next-PC path around `branch_predictor`. It picks the fetch next-PC from the predictor output and carries each fetched instruction's prediction through the D and X stages. When X resolves a branch, it compares the real outcome with the prediction, sends the outcome back to the predictor as `x_predict_res`, and on a mismatch flushes the front end and redirects fetch. It also keeps saturating branch and mispredict counters for performance analysis.

---
 rtl/branch_redirect_ctrl.sv | 130 +++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_redirect_ctrl.sv
// Next-PC selection and misprediction recovery around the branch predictor.
// Carries each fetched PC's prediction through D and X, resolves it in X and redirects on mismatch.
module branch_redirect_ctrl #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       CNT_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 'h1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [ADDR_W-1:0] f_pc,
    input  logic              f_predict_valid,
    input  logic [ADDR_W-1:0] f_predict_addr,
    input  logic              d_is_branch,
    input  logic              x_valid,
    input  logic              x_taken,
    input  logic [ADDR_W-1:0] x_target,
    output logic [ADDR_W-1:0] next_pc,
    output logic              flush,
    output logic              x_predict_res,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispredict_cnt
);

    typedef enum logic {S_RUN, S_REDIRECT} state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    state_t r_state, w_state_nxt;

    logic              r_d_valid, r_d_pred_taken;
    logic [ADDR_W-1:0] r_d_pc, r_d_pred_addr;
    logic              r_x_valid, r_x_pred_taken, r_x_is_branch;
    logic [ADDR_W-1:0] r_x_pc, r_x_pred_addr;
    logic [ADDR_W-1:0] r_rec_pc;
    logic              r_pred_res;
    logic [CNT_W-1:0]  r_branch_cnt, r_mispredict_cnt;

    logic              w_flush, w_live, w_accept, w_mp;
    logic              w_dir_wrong, w_tgt_wrong, w_alias;
    logic [ADDR_W-1:0] w_rec_pc, w_next_pc;
    logic              w_unused;

    // X is only judged when it holds a live instruction and the pipe actually advances
    assign w_live      = r_x_valid & ~stall & ~w_flush;
    assign w_accept    = w_live & x_valid;
    assign w_dir_wrong = x_valid & (x_taken != r_x_pred_taken);
    assign w_tgt_wrong = x_valid & x_taken & (x_target != r_x_pred_addr);
    assign w_alias     = ~x_valid & r_x_pred_taken;
    assign w_mp        = w_live & (w_dir_wrong | w_tgt_wrong | w_alias);
    assign w_rec_pc    = (x_valid & x_taken) ? x_target : r_x_pc + PC_STEP;
    assign w_unused    = r_x_is_branch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_RUN;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:      if (w_mp)   w_state_nxt = S_REDIRECT;
            S_REDIRECT: if (!stall) w_state_nxt = S_RUN;
            default:                w_state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        w_flush   = (r_state == S_REDIRECT);
        w_next_pc = f_pc + PC_STEP;
        if (reset)                  w_next_pc = RESET_PC;
        else if (w_flush)           w_next_pc = r_rec_pc;
        else if (stall)             w_next_pc = f_pc;
        else if (f_predict_valid)   w_next_pc = f_predict_addr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_d_valid      <= 1'b0;
            r_d_pc         <= '0;
            r_d_pred_taken <= 1'b0;
            r_d_pred_addr  <= '0;
            r_x_valid      <= 1'b0;
            r_x_pc         <= '0;
            r_x_pred_taken <= 1'b0;
            r_x_pred_addr  <= '0;
            r_x_is_branch  <= 1'b0;
        end else if (w_flush) begin
            r_d_valid <= 1'b0;
            r_x_valid <= 1'b0;
        end else if (!stall) begin
            r_d_valid      <= 1'b1;
            r_d_pc         <= f_pc;
            r_d_pred_taken <= f_predict_valid;
            r_d_pred_addr  <= f_predict_addr;
            r_x_valid      <= r_d_valid;
            r_x_pc         <= r_d_pc;
            r_x_pred_taken <= r_d_pred_taken;
            r_x_pred_addr  <= r_d_pred_addr;
            r_x_is_branch  <= d_is_branch;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     r_rec_pc <= RESET_PC;
        else if (w_mp) r_rec_pc <= w_rec_pc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pred_res       <= 1'b0;
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            r_pred_res <= w_accept & x_taken;
            if (w_accept && (r_branch_cnt != '1))
                r_branch_cnt <= r_branch_cnt + CNT_ONE;
            if (w_mp && (r_mispredict_cnt != '1))
                r_mispredict_cnt <= r_mispredict_cnt + CNT_ONE;
        end
    end

    assign next_pc        = w_next_pc;
    assign flush          = w_flush;
    assign x_predict_res  = r_pred_res;
    assign branch_cnt     = r_branch_cnt;
    assign mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed scenarios plus randomized traffic
// against a transaction-level model of the D/X prediction pipeline.
module tb_branch_redirect_ctrl;

    localparam logic [31:0] RPC = 32'h1000;

    logic        clk = 1'b0;
    logic        reset, stall, f_predict_valid, d_is_branch, x_valid, x_taken;
    logic [31:0] f_pc, f_predict_addr, x_target;
    logic [31:0] next_pc, s_next_pc;
    logic        flush, x_predict_res, s_flush, s_x_predict_res;
    logic [15:0] branch_cnt, mispredict_cnt;
    logic [1:0]  s_branch_cnt, s_mispredict_cnt;

    branch_redirect_ctrl #(.ADDR_W(32), .CNT_W(16), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .stall(stall), .f_pc(f_pc),
        .f_predict_valid(f_predict_valid), .f_predict_addr(f_predict_addr),
        .d_is_branch(d_is_branch), .x_valid(x_valid), .x_taken(x_taken), .x_target(x_target),
        .next_pc(next_pc), .flush(flush), .x_predict_res(x_predict_res),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    // Narrow-counter copy so saturation is reached with real mispredicts
    branch_redirect_ctrl #(.ADDR_W(32), .CNT_W(2), .RESET_PC(RPC)) dut_s (
        .clk(clk), .reset(reset), .stall(stall), .f_pc(f_pc),
        .f_predict_valid(f_predict_valid), .f_predict_addr(f_predict_addr),
        .d_is_branch(d_is_branch), .x_valid(x_valid), .x_taken(x_taken), .x_target(x_target),
        .next_pc(s_next_pc), .flush(s_flush), .x_predict_res(s_x_predict_res),
        .branch_cnt(s_branch_cnt), .mispredict_cnt(s_mispredict_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          v;
        logic [31:0] pc;
        bit          pt;
        logic [31:0] pa;
        bit          br;
    } tag_t;

    tag_t        m_d, m_x;
    bit          m_redir, m_res;
    logic [31:0] m_rec, fpc, e_npc;
    int          n_br, n_mp;
    bit          e_mp, e_acc;

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic model_reset();
        m_d.v = 0; m_x.v = 0; m_redir = 0; m_res = 0; m_rec = RPC; n_br = 0; n_mp = 0;
    endtask

    // Apply one cycle of inputs, predict the combinational outputs, then wait for the negedge
    task automatic drive(input bit rst, input bit st, input bit pv, input logic [31:0] pa,
                         input bit dbr, input bit xv, input bit xt, input logic [31:0] xtg);
        reset = rst; stall = st; f_pc = fpc; f_predict_valid = pv; f_predict_addr = pa;
        d_is_branch = dbr; x_valid = xv; x_taken = xt; x_target = xtg;
        if (rst) model_reset();
        e_mp  = !rst && m_x.v && !st && !m_redir &&
                (xv ? ((xt != m_x.pt) || (xt && xtg != m_x.pa)) : m_x.pt);
        e_acc = !rst && m_x.v && !st && !m_redir && xv;
        if (rst)          e_npc = RPC;
        else if (m_redir) e_npc = m_rec;
        else if (st)      e_npc = fpc;
        else if (pv)      e_npc = pa;
        else              e_npc = fpc + 32'd4;
        @(negedge clk);
    endtask

    task automatic advance();
        bit was_redir;
        @(posedge clk);
        if (!reset) begin
            was_redir = m_redir;
            if (e_mp) m_rec = (x_valid && x_taken) ? x_target : m_x.pc + 32'd4;
            m_res = e_acc ? x_taken : 1'b0;
            n_br += int'(e_acc);
            n_mp += int'(e_mp);
            m_redir = was_redir ? stall : e_mp;
            if (was_redir) begin
                m_d.v = 0; m_x.v = 0;
            end else if (!stall) begin
                m_x = m_d; m_x.br = d_is_branch;
                m_d.v = 1; m_d.pc = fpc; m_d.pt = f_predict_valid; m_d.pa = f_predict_addr; m_d.br = 0;
            end
        end
        fpc = e_npc;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 0, '0, 0, 0, 0, '0);
            advance();
        end
    endtask

    task automatic test_reset();
        fpc = RPC;
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 1, 32'h5000, 1, 1, 1, 32'h6000);
            checks++; if (next_pc !== RPC) begin errors++; $display("FAIL rst_npc got %h exp %h", next_pc, RPC); end
            checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %b exp 0", flush); end
            checks++; if (x_predict_res !== 1'b0) begin errors++; $display("FAIL rst_res got %b exp 0", x_predict_res); end
            checks++; if (branch_cnt !== 16'd0 || mispredict_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", branch_cnt, mispredict_cnt); end
            advance();
        end
    endtask

    task automatic test_sequential();
        drive(0, 0, 0, '0, 0, 0, 0, '0);
        checks++; if (next_pc !== 32'h1004) begin errors++; $display("FAIL seq_npc1 got %h exp 1004", next_pc); end
        advance();
        drive(0, 0, 0, '0, 0, 0, 0, '0);
        checks++; if (next_pc !== 32'h1008 || f_pc !== 32'h1004) begin errors++; $display("FAIL seq_npc2 got %h/%h exp 1008/1004", next_pc, f_pc); end
        checks++; if (flush !== 1'b0 || branch_cnt !== 16'd0 || mispredict_cnt !== 16'd0) begin errors++; $display("FAIL seq_state got %b/%0d/%0d exp 0/0/0", flush, branch_cnt, mispredict_cnt); end
        advance();
    endtask

    task automatic test_correct_taken();
        fpc = 32'h1014;
        drive(0, 0, 1, 32'h1000, 0, 0, 0, '0);
        checks++; if (next_pc !== 32'h1000) begin errors++; $display("FAIL ct_npc got %h exp 1000", next_pc); end
        advance();
        drive(0, 0, 0, '0, 1, 0, 0, '0); advance();
        drive(0, 0, 0, '0, 0, 1, 1, 32'h1000);
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL ct_noflush got %b exp 0", flush); end
        advance();
        drive(0, 0, 0, '0, 0, 0, 0, '0);
        checks++; if (x_predict_res !== 1'b1 || flush !== 1'b0) begin errors++; $display("FAIL ct_res got %b/%b exp 1/0", x_predict_res, flush); end
        checks++; if (branch_cnt !== 16'd1 || mispredict_cnt !== 16'd0) begin errors++; $display("FAIL ct_cnt got %0d/%0d exp 1/0", branch_cnt, mispredict_cnt); end
        advance();
    endtask

    task automatic test_direction_mp();
        fpc = 32'h100c;
        drive(0, 0, 0, '0, 0, 0, 0, '0); advance();
        drive(0, 0, 0, '0, 1, 0, 0, '0); advance();
        drive(0, 0, 0, '0, 0, 1, 1, 32'h1014); advance();
        drive(0, 0, 0, '0, 0, 1, 1, 32'h3000);
        checks++; if (flush !== 1'b1 || next_pc !== 32'h1014) begin errors++; $display("FAIL dir_redirect got %b/%h exp 1/1014", flush, next_pc); end
        checks++; if (mispredict_cnt !== 16'd1 || branch_cnt !== 16'd2) begin errors++; $display("FAIL dir_cnt got %0d/%0d exp 1/2", mispredict_cnt, branch_cnt); end
        advance();
        drive(0, 0, 0, '0, 0, 1, 1, 32'h3000);
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL dir_oneflush got %b exp 0", flush); end
        advance();
        drive(0, 0, 0, '0, 0, 1, 1, 32'h3000);
        checks++; if (x_predict_res !== 1'b0 || branch_cnt !== 16'd2) begin errors++; $display("FAIL dir_tag_inv1 got %b/%0d exp 0/2", x_predict_res, branch_cnt); end
        advance();
        drive(0, 0, 0, '0, 0, 0, 0, '0);
        checks++; if (x_predict_res !== 1'b0 || branch_cnt !== 16'd2 || mispredict_cnt !== 16'd1) begin errors++; $display("FAIL dir_tag_inv2 got %b/%0d/%0d exp 0/2/1", x_predict_res, branch_cnt, mispredict_cnt); end
        advance();
    endtask

    task automatic test_not_taken_mp();
        fpc = 32'h1008;
        drive(0, 0, 1, 32'h1010, 0, 0, 0, '0);
        checks++; if (next_pc !== 32'h1010) begin errors++; $display("FAIL nt_pred got %h exp 1010", next_pc); end
        advance();
        drive(0, 0, 0, '0, 1, 0, 0, '0); advance();
        drive(0, 0, 0, '0, 0, 1, 0, 32'h1010); advance();
        drive(0, 0, 0, '0, 0, 0, 0, '0);
        checks++; if (flush !== 1'b1 || next_pc !== 32'h100c) begin errors++; $display("FAIL nt_redirect got %b/%h exp 1/100c", flush, next_pc); end
        checks++; if (x_predict_res !== 1'b0 || mispredict_cnt !== 16'd2 || branch_cnt !== 16'd3) begin errors++; $display("FAIL nt_fb got %b/%0d/%0d exp 0/2/3", x_predict_res, mispredict_cnt, branch_cnt); end
        advance();
        idle(1);
    endtask

    task automatic test_alias();
        fpc = 32'h1010;
        drive(0, 0, 1, 32'h2000, 0, 0, 0, '0); advance();
        drive(0, 0, 0, '0, 0, 0, 0, '0); advance();
        drive(0, 0, 0, '0, 0, 0, 0, '0); advance();
        drive(0, 0, 0, '0, 0, 0, 0, '0);
        checks++; if (flush !== 1'b1 || next_pc !== 32'h1014) begin errors++; $display("FAIL alias_redirect got %b/%h exp 1/1014", flush, next_pc); end
        checks++; if (branch_cnt !== 16'd3 || mispredict_cnt !== 16'd3) begin errors++; $display("FAIL alias_cnt got %0d/%0d exp 3/3", branch_cnt, mispredict_cnt); end
        advance();
        idle(2);
    endtask

    task automatic test_stall();
        fpc = 32'h1020;
        drive(0, 0, 0, '0, 0, 0, 0, '0); advance();
        drive(0, 0, 0, '0, 1, 0, 0, '0); advance();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, '0, 0, 1, 1, 32'h1040);
            checks++; if (flush !== 1'b0 || next_pc !== 32'h1028) begin errors++; $display("FAIL stall_hold%0d got %b/%h exp 0/1028", i, flush, next_pc); end
            advance();
        end
        drive(0, 0, 0, '0, 0, 1, 1, 32'h1040);
        checks++; if (flush !== 1'b0 || mispredict_cnt !== 16'd3) begin errors++; $display("FAIL stall_release got %b/%0d exp 0/3", flush, mispredict_cnt); end
        advance();
        drive(0, 0, 0, '0, 0, 0, 0, '0);
        checks++; if (flush !== 1'b1 || next_pc !== 32'h1040) begin errors++; $display("FAIL stall_redirect got %b/%h exp 1/1040", flush, next_pc); end
        checks++; if (mispredict_cnt !== 16'd4 || branch_cnt !== 16'd4 || x_predict_res !== 1'b1) begin errors++; $display("FAIL stall_cnt got %0d/%0d/%b exp 4/4/1", mispredict_cnt, branch_cnt, x_predict_res); end
        advance();
        drive(0, 0, 0, '0, 0, 0, 0, '0);
        checks++; if (flush !== 1'b0 || mispredict_cnt !== 16'd4) begin errors++; $display("FAIL stall_single got %b/%0d exp 0/4", flush, mispredict_cnt); end
        advance();
    endtask

    task automatic test_reset_mid_redirect();
        fpc = 32'h1030;
        drive(0, 0, 1, 32'h1100, 0, 0, 0, '0); advance();
        drive(0, 0, 0, '0, 0, 0, 0, '0); advance();
        drive(0, 0, 0, '0, 0, 0, 0, '0); advance();
        drive(1, 0, 0, '0, 0, 0, 0, '0);
        checks++; if (flush !== 1'b0 || next_pc !== RPC) begin errors++; $display("FAIL midrst got %b/%h exp 0/1000", flush, next_pc); end
        checks++; if (branch_cnt !== 16'd0 || mispredict_cnt !== 16'd0) begin errors++; $display("FAIL midrst_cnt got %0d/%0d exp 0/0", branch_cnt, mispredict_cnt); end
        advance();
        drive(0, 0, 0, '0, 0, 0, 0, '0);
        checks++; if (flush !== 1'b0 || next_pc !== 32'h1004) begin errors++; $display("FAIL midrst_run got %b/%h exp 0/1004", flush, next_pc); end
        advance();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            fpc = 32'h1200 + 32'(i) * 32'h10;
            drive(0, 0, 1, 32'h4000, 0, 0, 0, '0); advance();
            drive(0, 0, 0, '0, 0, 0, 0, '0); advance();
            drive(0, 0, 0, '0, 0, 0, 0, '0); advance();
            drive(0, 0, 0, '0, 0, 0, 0, '0); advance();
        end
        drive(0, 0, 0, '0, 0, 0, 0, '0);
        checks++; if (s_mispredict_cnt !== 2'd3) begin errors++; $display("FAIL sat_small got %0d exp 3", s_mispredict_cnt); end
        checks++; if (mispredict_cnt !== 16'd5) begin errors++; $display("FAIL sat_wide got %0d exp 5", mispredict_cnt); end
        advance();
    endtask

    task automatic test_random();
        bit          rst, st, pv, dbr, xv, xt;
        logic [31:0] pa, xtg;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            st  = ($urandom_range(0, 4) == 0);
            pv  = ($urandom_range(0, 3) == 0);
            pa  = 32'h1000 + 32'($urandom_range(0, 255)) * 32'd4;
            dbr = $urandom_range(0, 1) == 1;
            xv  = ($urandom_range(0, 2) == 0);
            xt  = $urandom_range(0, 1) == 1;
            xtg = ($urandom_range(0, 1) == 1) ? m_x.pa : 32'h1000 + 32'($urandom_range(0, 255)) * 32'd4;
            drive(rst, st, pv, pa, dbr, xv, xt, xtg);
            checks++; if (next_pc !== e_npc) begin errors++; $display("FAIL rnd_npc cyc %0d got %h exp %h", i, next_pc, e_npc); end
            checks++; if (flush !== m_redir) begin errors++; $display("FAIL rnd_flush cyc %0d got %b exp %b", i, flush, m_redir); end
            checks++; if (x_predict_res !== m_res) begin errors++; $display("FAIL rnd_res cyc %0d got %b exp %b", i, x_predict_res, m_res); end
            checks++; if (int'(branch_cnt) != sat(n_br, 16)) begin errors++; $display("FAIL rnd_bcnt cyc %0d got %0d exp %0d", i, branch_cnt, sat(n_br, 16)); end
            checks++; if (int'(mispredict_cnt) != sat(n_mp, 16)) begin errors++; $display("FAIL rnd_mcnt cyc %0d got %0d exp %0d", i, mispredict_cnt, sat(n_mp, 16)); end
            checks++; if (int'(s_branch_cnt) != sat(n_br, 2)) begin errors++; $display("FAIL rnd_sbcnt cyc %0d got %0d exp %0d", i, s_branch_cnt, sat(n_br, 2)); end
            checks++; if (int'(s_mispredict_cnt) != sat(n_mp, 2)) begin errors++; $display("FAIL rnd_smcnt cyc %0d got %0d exp %0d", i, s_mispredict_cnt, sat(n_mp, 2)); end
            advance();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_correct_taken();
        test_direction_mp();
        test_not_taken_mp();
        test_alias();
        test_stall();
        test_reset_mid_redirect();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
